// File: rtl/cofre_code_sender.sv
// cofre_code_sender
//   Automatic key-entry master for the safe-lock digit bus. Replays a stored
//   CODE_LEN-digit password onto the 2-bit digit bus, one digit per clock, with
//   GAP_CYCLES idle cycles between digits. It then watches the lock's LED for
//   up to TIMEOUT cycles and reports either unlocked or timeout.
//   Bus encoding: 00 = idle / no key, 01 = A, 10 = B, 11 = C.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; overrides everything
//   start    in   begin transmission (sampled only in IDLE/DONE)
//   load     in   capture code_in into the code register (only in IDLE/DONE)
//   code_in  in   packed password, slot i in bits [2i+1:2i], slot 0 sent first
//   led_in   in   unlock indicator from the lock (sampled only in WAIT_ACK)
//   digito   out  registered digit bus to the lock
//   busy     out  high while sending, gapping or waiting for the LED
//   done     out  high in DONE
//   unlocked out  valid while done: LED was seen high
//   fail     out  valid while done: LED never came within TIMEOUT cycles
//   load_err out  one-cycle pulse when a load is rejected (a slot is 00)
module cofre_code_sender #(
    parameter int                    CODE_LEN     = 5,
    parameter int                    GAP_CYCLES   = 1,
    parameter int                    TIMEOUT      = 4,
    parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 10'b11_10_01_10_11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    load,
    input  logic [2*CODE_LEN-1:0]   code_in,
    input  logic                    led_in,
    output logic [1:0]              digito,
    output logic                    busy,
    output logic                    done,
    output logic                    unlocked,
    output logic                    fail,
    output logic                    load_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        GAP      = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [3:0] IDX_LAST = 4'(CODE_LEN - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t                  state_r;
    logic [2*CODE_LEN-1:0]   code_r;
    logic [3:0]              idx_r;
    logic [3:0]              gap_cnt_r;
    logic [7:0]              to_cnt_r;

    // A code is usable only if no slot holds the idle symbol 00, since the
    // lock would read such a slot as "no key pressed".
    function automatic logic code_valid(input logic [2*CODE_LEN-1:0] c);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (2'(c >> (2 * i)) == 2'b00) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Extract slot idx from a packed code (shift avoids a variable part-select).
    function automatic logic [1:0] slot(input logic [2*CODE_LEN-1:0] c,
                                        input logic [3:0]            idx);
        return 2'(c >> {idx, 1'b0});
    endfunction

    // Sequencer: state, counters, code register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            code_r    <= DEFAULT_CODE;
            idx_r     <= 4'd0;
            gap_cnt_r <= 4'd0;
            to_cnt_r  <= 8'd0;
            digito    <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            unlocked  <= 1'b0;
            fail      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    // load wins over start; a start in the same cycle is dropped
                    if (load) begin
                        if (code_valid(code_in)) begin
                            code_r   <= code_in;
                            state_r  <= IDLE;
                            done     <= 1'b0;
                            unlocked <= 1'b0;
                            fail     <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (start) begin
                        state_r  <= SEND;
                        idx_r    <= 4'd0;
                        digito   <= slot(code_r, 4'd0);
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        unlocked <= 1'b0;
                        fail     <= 1'b0;
                    end
                end
                SEND: begin
                    if (idx_r == IDX_LAST) begin
                        state_r  <= WAIT_ACK;
                        digito   <= 2'b00;
                        to_cnt_r <= 8'd0;
                    end else if (GAP_CYCLES > 0) begin
                        state_r   <= GAP;
                        digito    <= 2'b00;
                        gap_cnt_r <= 4'd0;
                    end else begin
                        idx_r  <= idx_r + 4'd1;
                        digito <= slot(code_r, idx_r + 4'd1);
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= SEND;
                        idx_r   <= idx_r + 4'd1;
                        digito  <= slot(code_r, idx_r + 4'd1);
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end
                end
                WAIT_ACK: begin
                    // LED wins over timeout when both occur in the final cycle
                    if (led_in) begin
                        state_r  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        unlocked <= 1'b1;
                        fail     <= 1'b0;
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        unlocked <= 1'b0;
                        fail     <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    digito   <= 2'b00;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    unlocked <= 1'b0;
                    fail     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cofre_code_sender.sv
// Directed bench for cofre_code_sender: one instance with default parameters
// (GAP_CYCLES = 1) and one built with GAP_CYCLES = 0. Expected bus sequences
// are derived from the packed code given to each check routine.
module tb_cofre_code_sender;

    localparam logic [9:0] DEF_CODE  = 10'b11_10_01_10_11;
    localparam logic [9:0] CODE_A    = 10'b01_01_11_10_01;
    localparam logic [9:0] CODE_BAD  = 10'b11_00_10_10_01;
    localparam logic [9:0] CODE_B    = 10'b10_11_01_11_10;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, load, led_in;
    logic [9:0] code_in;
    logic [1:0] digito;
    logic       busy, done, unlocked, fail, load_err;

    logic       start0;
    logic [1:0] digito0;
    logic       busy0, done0, unlocked0, fail0, load_err0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cofre_code_sender dut (
        .clk(clk), .reset(reset), .start(start), .load(load),
        .code_in(code_in), .led_in(led_in), .digito(digito), .busy(busy),
        .done(done), .unlocked(unlocked), .fail(fail), .load_err(load_err)
    );

    cofre_code_sender #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .load(1'b0),
        .code_in(DEF_CODE), .led_in(1'b0), .digito(digito0), .busy(busy0),
        .done(done0), .unlocked(unlocked0), .fail(fail0), .load_err(load_err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: check the digit, optionally glitch start/load, advance.
    task automatic step_chk(input logic [1:0] exp, input bit glitch);
        check("digito", 32'(digito), 32'(exp));
        check("busy", 32'(busy), 32'd1);
        check("load_err", 32'(load_err), 32'd0);
        if (glitch) begin
            start = 1'b1; load = 1'b1; code_in = CODE_BAD;
        end
        tick();
        start = 1'b0; load = 1'b0;
    endtask

    // Full transmission of a 5-slot code with one idle cycle between digits.
    task automatic run_seq(input logic [9:0] code, input int glitch_step);
        logic [9:0] c;
        int step;
        c = code;
        step = 0;
        for (int i = 0; i < 5; i++) begin
            step_chk(c[2*i +: 2], step == glitch_step);
            step++;
            if (i < 4) begin
                step_chk(2'b00, step == glitch_step);
                step++;
            end
        end
    endtask

    task automatic wait_timeout;
        for (int k = 0; k < 4; k++) begin
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_digito", 32'(digito), 32'd0);
            check("wait_done", 32'(done), 32'd0);
            tick();
        end
        check("to_done", 32'(done), 32'd1);
        check("to_fail", 32'(fail), 32'd1);
        check("to_unlocked", 32'(unlocked), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load = 1'b0; led_in = 1'b0;
        code_in = 10'd0; start0 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_digito", 32'(digito), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_unlocked", 32'(unlocked), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);

        // Default code, LED never comes: timeout after 4 WAIT_ACK cycles
        pulse_start();
        run_seq(DEF_CODE, -1);
        wait_timeout();

        // LED goes high one cycle after the final digit
        pulse_start();
        run_seq(DEF_CODE, 8);
        check("ack_busy", 32'(busy), 32'd1);
        check("ack_digito", 32'(digito), 32'd0);
        led_in = 1'b1;
        tick();
        led_in = 1'b0;
        check("ack_done", 32'(done), 32'd1);
        check("ack_unlocked", 32'(unlocked), 32'd1);
        check("ack_fail", 32'(fail), 32'd0);
        check("ack_busy_low", 32'(busy), 32'd0);
        tick();
        check("ack_hold", 32'(unlocked), 32'd1);

        // Valid load clears results, no error pulse
        load = 1'b1; code_in = CODE_A;
        tick();
        load = 1'b0;
        check("loadA_err", 32'(load_err), 32'd0);
        check("loadA_done", 32'(done), 32'd0);
        check("loadA_unl", 32'(unlocked), 32'd0);
        pulse_start();
        run_seq(CODE_A, -1);
        wait_timeout();

        // Load with a 00 slot is rejected: one-cycle error, results kept
        load = 1'b1; code_in = CODE_BAD;
        tick();
        load = 1'b0;
        check("bad_err", 32'(load_err), 32'd1);
        check("bad_done_kept", 32'(done), 32'd1);
        tick();
        check("bad_err_pulse", 32'(load_err), 32'd0);
        pulse_start();
        run_seq(CODE_A, -1);
        wait_timeout();

        // load and start together: code taken, start dropped
        load = 1'b1; start = 1'b1; code_in = CODE_B;
        tick();
        load = 1'b0; start = 1'b0;
        check("ls_busy", 32'(busy), 32'd0);
        check("ls_digito", 32'(digito), 32'd0);
        tick();
        check("ls_busy2", 32'(busy), 32'd0);
        // start/load glitch at cycle 3 of transmission must not disturb it
        pulse_start();
        run_seq(CODE_B, 3);
        wait_timeout();

        // Reset in the gap after the second digit
        pulse_start();
        step_chk(2'b10, 1'b0);
        step_chk(2'b00, 1'b0);
        step_chk(2'b11, 1'b0);
        check("pre_rst_digito", 32'(digito), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_digito", 32'(digito), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        check("mid_rst_idle", 32'(busy), 32'd0);
        pulse_start();
        run_seq(DEF_CODE, -1);
        wait_timeout();

        // GAP_CYCLES = 0 build: digits back-to-back
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [9:0] c;
            c = DEF_CODE;
            check("g0_digito", 32'(digito0), 32'(c[2*i +: 2]));
            check("g0_busy", 32'(busy0), 32'd1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            check("g0_wait_digito", 32'(digito0), 32'd0);
            check("g0_wait_busy", 32'(busy0), 32'd1);
            tick();
        end
        check("g0_done", 32'(done0), 32'd1);
        check("g0_fail", 32'(fail0), 32'd1);
        check("g0_unlocked", 32'(unlocked0), 32'd0);
        check("g0_load_err", 32'(load_err0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cofre_code_sender.md
Name: cofre_code_sender

Overview:
- Transmitter end of the safe-lock digit bus. Replays a stored N-digit password onto the 2-bit `digito` bus, one digit per clock, with programmable idle gaps.
- Watches the lock's `led` output, then reports unlocked or timeout.
- Used as an automatic key-entry master for the lock FSM, on board and in system benches.
- Bus encoding: 00 = no key/idle, 01 = A, 10 = B, 11 = C.

Parameters:
- CODE_LEN, 5, number of digits in the password (1..16).
- GAP_CYCLES, 1, idle (00) cycles inserted between consecutive digits (0..15). No gap after the last digit.
- TIMEOUT, 4, maximum cycles spent in WAIT_ACK sampling led_in (1..255).
- DEFAULT_CODE, 10'b11_10_01_10_11, reset password in packed form. Slot 0 is in bits [1:0] and is sent first. Default is C,B,A,B,C.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin transmission; one-cycle pulse or level, sampled only in IDLE/DONE
- load  in  1  capture code_in into code register; honoured only in IDLE/DONE
- code_in  in  2*CODE_LEN  packed password, slot i in bits [2i+1:2i]
- led_in  in  1  unlock indicator from the lock
- digito  out  2  registered digit bus to the lock
- busy  out  1  high in SEND, GAP, WAIT_ACK
- done  out  1  high in DONE
- unlocked  out  1  valid while done; 1 = led_in seen high
- fail  out  1  valid while done; 1 = timeout
- load_err  out  1  one-cycle pulse: load rejected

Behaviour:
- Reset (synchronous, active-high) overrides everything, including mid-transmission:
  - state = IDLE
  - digito = 00; busy, done, unlocked, fail, load_err = 0
  - code_reg = DEFAULT_CODE; idx, gap_cnt, to_cnt = 0
- All outputs are registered.
- States:
  - IDLE
  - SEND: digito = code_reg slot idx, held exactly 1 cycle.
  - GAP: digito = 00.
  - WAIT_ACK: digito = 00; to_cnt counts cycles.
  - DONE: digito = 00; results held.
- Load, in IDLE/DONE:
  - If every slot of code_in is nonzero, code_reg <= code_in at the next edge.
  - If any slot of code_in is 00, code_reg is unchanged and load_err pulses for 1 cycle.
  - load has priority over start in the same cycle; that start is dropped.
  - load in any other state is ignored, with no load_err.
- Start, in IDLE/DONE with load = 0:
  - Next edge: state = SEND, idx = 0, digito = slot 0, busy = 1.
  - done, unlocked and fail clear at that same edge.
- SEND → GAP when idx < CODE_LEN-1 and GAP_CYCLES > 0.
- SEND → SEND(idx+1) when idx < CODE_LEN-1 and GAP_CYCLES = 0.
- SEND → WAIT_ACK when idx = CODE_LEN-1; to_cnt = 0.
- GAP lasts exactly GAP_CYCLES cycles, then SEND(idx+1).
- Transmission length: CODE_LEN + (CODE_LEN-1)*GAP_CYCLES cycles of bus activity.
- WAIT_ACK:
  - led_in is sampled every cycle.
  - If led_in = 1 → DONE with unlocked = 1, fail = 0.
  - Else, when to_cnt reaches TIMEOUT-1 → DONE with fail = 1, unlocked = 0.
  - So WAIT_ACK lasts at most TIMEOUT cycles.
  - led_in is ignored in every other state.
- DONE: holds done, unlocked and fail until start or load is accepted (load clears done/unlocked/fail only on a successful load).
- start while busy is ignored; there is no abort other than reset.
- Single-digit code (CODE_LEN = 1): SEND → WAIT_ACK directly.

Test Plan:
- Reset, then start with defaults (GAP_CYCLES=1) → digito sequence 11,00,10,00,01,00,10,00,11, then 00; busy high for those 9 cycles plus WAIT_ACK; with led_in=0 throughout → after 4 WAIT_ACK cycles done=1, fail=1, unlocked=0.
- Same start, led_in driven high 1 cycle after the final 11 → next edge done=1, unlocked=1, fail=0; busy=0.
- In IDLE, load code_in=10'b01_01_11_10_01 → no load_err; start → digito 01,00,10,00,11,00,01,00,01. Then load 10'b11_00_10_10_01 → load_err pulse 1 cycle; the next start still sends the previous code.
- load=1 and start=1 in the same cycle → code updated, state remains IDLE, busy=0; start pulse while busy (cycle 3 of SEND/GAP) → sequence unaffected.
- Assert reset during GAP after the second digit → next edge digito=00, busy=0, code_reg=DEFAULT_CODE; a fresh start then emits 11 first.
- GAP_CYCLES=0 build with default code → digito 11,10,01,10,11 on 5 consecutive cycles, then WAIT_ACK.
